// File: rtl/phase_sampler_pkg.sv
// Shared definitions for the oscillator phase sampler: FSM encoding,
// default counter width, register map offsets and the spin decision rule.
package phase_sampler_pkg;

    typedef enum logic [1:0] {
        PS_IDLE   = 2'd0,
        PS_SAMPLE = 2'd1,
        PS_DONE   = 2'd2
    } ps_state_t;

    localparam int CNT_W_DEFAULT = 16;

    // Byte offsets seen by firmware through the register wrapper.
    localparam logic [7:0] REG_WINDOW     = 8'h00;
    localparam logic [7:0] REG_START      = 8'h04;
    localparam logic [7:0] REG_STATUS     = 8'h08;
    localparam logic [7:0] REG_COUNT_BASE = 8'h10;

    // Anti-phase when strictly more than half the samples mismatched;
    // an exact half is a tie and resolves to 0.
    function automatic logic spin_decision(input logic [31:0] count,
                                           input logic [31:0] win);
        return count > (win >> 1);
    endfunction

endpackage

// File: rtl/phase_sync_counter.sv
// One oscillator lane: metastability synchronizer followed by a mismatch
// counter that compares the synchronized tap against the reference tap.
module phase_sync_counter
    import phase_sampler_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             axi_rstn,
    input  logic             osc,
    input  logic             ref_bit,
    input  logic             clear,
    input  logic             enable,
    output logic             synced,
    output logic [CNT_W-1:0] count
);

    logic [SYNC_STAGES-1:0] chain;

    // Free-running synchronizer; runs in every state so the lane is settled
    // before a measurement starts.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], osc};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

    // Count samples where this lane disagrees with the reference.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (synced ^ ref_bit)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/phase_sampler.sv
// Measures the phase of every oscillator tap against the reference tap
// bot_row[N-1] over a programmable window and derives a spin per tap.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PS_IDLE   | waiting for start; results from the last run are held
// PS_SAMPLE | one sample per clk into every lane counter, win_q samples
// PS_DONE   | single cycle; spins and done are registered on leaving it
module phase_sampler
    import phase_sampler_pkg::*;
#(
    parameter int N           = 8,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 axi_rstn,
    input  logic [N-1:0]         bot_row,
    input  logic                 start,
    input  logic [CNT_W-1:0]     window,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         spins,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic [CNT_W-1:0]     rd_count
);

    ps_state_t        state;
    ps_state_t        state_nxt;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] remaining;
    logic             clear;
    logic             enable;
    logic [N-1:0]     s;
    logic [CNT_W-1:0] count [N];
    logic [N-1:0]     spins_calc;

    generate
        for (genvar g = 0; g < N; g++) begin : g_lane
            phase_sync_counter #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_lane (
                .clk      (clk),
                .axi_rstn (axi_rstn),
                .osc      (bot_row[g]),
                .ref_bit  (s[N-1]),
                .clear    (clear),
                .enable   (enable),
                .synced   (s[g]),
                .count    (count[g])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state <= PS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and lane controls; a zero window skips sampling entirely.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        enable    = 1'b0;
        case (state)
            PS_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = (window == '0) ? PS_DONE : PS_SAMPLE;
                end
            end
            PS_SAMPLE: begin
                enable = 1'b1;
                if (remaining == '0) begin
                    state_nxt = PS_DONE;
                end
            end
            PS_DONE: begin
                state_nxt = PS_IDLE;
            end
            default: begin
                state_nxt = PS_IDLE;
            end
        endcase
    end

    // Window capture and down-counting sample timer; terminal count zero
    // marks the final sample.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            win_q     <= '0;
            remaining <= '0;
        end else if (state == PS_IDLE && start) begin
            win_q     <= window;
            remaining <= window - CNT_W'(1);
        end else if (state == PS_SAMPLE && remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Per-lane majority decision against half the window.
    always_comb begin
        spins_calc = '0;
        for (int i = 0; i < N; i++) begin
            spins_calc[i] = spin_decision(32'(count[i]), 32'(win_q));
        end
    end

    // Result registers; spins only change when a run completes.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            done  <= 1'b0;
            spins <= '0;
        end else begin
            done <= (state == PS_DONE);
            if (state == PS_DONE) begin
                spins <= spins_calc;
            end
        end
    end

    assign busy     = (state == PS_SAMPLE);
    assign rd_count = count[rd_addr];

endmodule

// File: tb/tb_phase_sampler.sv
// Self-checking bench for phase_sampler. The reference model keeps a log of
// the tap values presented at every clock edge and computes each expected
// count as the number of sample edges where the tap, seen SYNC edges late,
// differs from the reference tap.
module tb_phase_sampler;

    localparam int N     = 8;
    localparam int CNT_W = 16;
    localparam int SYNC  = 2;

    logic             clk;
    logic             axi_rstn;
    logic [N-1:0]     bot_row;
    logic             start;
    logic [CNT_W-1:0] window;
    logic             busy;
    logic             done;
    logic [N-1:0]     spins;
    logic [2:0]       rd_addr;
    logic [CNT_W-1:0] rd_count;

    int errors;
    int checks;
    int cyc;
    logic [N-1:0] hist [0:131071];

    phase_sampler #(.N(N), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .axi_rstn (axi_rstn),
        .bot_row  (bot_row),
        .start    (start),
        .window   (window),
        .busy     (busy),
        .done     (done),
        .spins    (spins),
        .rd_addr  (rd_addr),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log the taps present at each edge; cyc becomes the index of the next edge.
    always @(posedge clk) begin
        hist[cyc] = bot_row;
        cyc = cyc + 1;
    end

    function automatic int model_count(input int i, input int k, input int w);
        int n;
        n = 0;
        for (int e = k + 1; e <= k + w; e++) begin
            n += int'(hist[e-SYNC][i] ^ hist[e-SYNC][N-1]);
        end
        return n;
    endfunction

    // Advance one clock and then update the taps: 0 static, 1 random, 2 squares.
    task automatic step(input int mode);
        logic r;
        logic q;
        @(posedge clk);
        #1;
        case (mode)
            1: bot_row = N'($urandom);
            2: begin
                r = 1'(((cyc) / 4) % 2);
                q = 1'(((cyc + 6) / 4) % 2);
                bot_row = {r, 1'b0, q, 1'b0, 1'b0, ~r, r, 1'b0};
            end
            default: ;
        endcase
    endtask

    // Run one measurement; optionally pulse start again restart_at cycles in.
    // Returns the accept edge, the number of done pulses, the edge of the last
    // one and how many cycles busy deviated from its expected shape.
    task automatic measure(input int w, input int mode, input int restart_at,
                           output int k, output int nd, output int de, output int bb);
        int e;
        k  = 0;
        nd = 0;
        de = -1;
        bb = 0;
        for (int c = 0; c <= w + 4; c++) begin
            start = (c == 0) || (restart_at > 0 && c == restart_at);
            if (c == 0) window = CNT_W'(w);
            step(mode);
            start  = 1'b0;
            window = CNT_W'($urandom);
            e = cyc - 1;
            if (c == 0) k = e;
            if (busy !== 1'(e < k + w)) bb++;
            if (done === 1'b1) begin
                nd++;
                de = e;
            end
        end
    endtask

    task automatic test_reset();
        axi_rstn = 1'b0;
        start    = 1'b0;
        window   = '0;
        bot_row  = '0;
        rd_addr  = '0;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%0b done=%0b expected 0 0", busy, done);
        end
        checks++;
        if (spins !== '0) begin
            errors++;
            $display("FAIL reset_spins: got %h expected 00", spins);
        end
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== '0) begin
                errors++;
                $display("FAIL reset_count[%0d]: got %0d expected 0", i, rd_count);
            end
        end
        repeat (3) step(0);
        axi_rstn = 1'b1;
        repeat (5) step(0);
    endtask

    task automatic test_static_antiphase();
        int k, nd, de, bb;
        bot_row = 8'b0000_1000;
        repeat (10) step(0);
        measure(100, 0, 0, k, nd, de, bb);
        checks++;
        if (nd !== 1 || de !== k + 101) begin
            errors++;
            $display("FAIL static_done: pulses=%0d at edge %0d expected 1 at %0d", nd, de, k + 101);
        end
        checks++;
        if (bb !== 0) begin
            errors++;
            $display("FAIL static_busy: bad cycles=%0d expected 0", bb);
        end
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== CNT_W'((i == 3) ? 100 : 0)) begin
                errors++;
                $display("FAIL static_count[%0d]: got %0d expected %0d", i, rd_count, (i == 3) ? 100 : 0);
            end
        end
        checks++;
        if (spins !== 8'b0000_1000) begin
            errors++;
            $display("FAIL static_spins: got %b expected 00001000", spins);
        end
    endtask

    task automatic test_square();
        int k, nd, de, bb, ex;
        logic [N-1:0] es;
        repeat (12) step(2);
        measure(64, 2, 0, k, nd, de, bb);
        checks++;
        if (nd !== 1 || de !== k + 65) begin
            errors++;
            $display("FAIL square_done: pulses=%0d at edge %0d expected 1 at %0d", nd, de, k + 65);
        end
        es = '0;
        for (int i = 0; i < N; i++) begin
            ex = model_count(i, k, 64);
            es[i] = (ex > 32);
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== CNT_W'(ex)) begin
                errors++;
                $display("FAIL square_count[%0d]: got %0d expected %0d", i, rd_count, ex);
            end
        end
        checks++;
        if (spins !== es || spins[2] !== 1'b1 || spins[1] !== 1'b0 || spins[5] !== 1'b0) begin
            errors++;
            $display("FAIL square_spins: got %b expected %b", spins, es);
        end
    endtask

    task automatic test_window_edges();
        int k, nd, de, bb;
        bot_row = 8'h5a;
        repeat (4) step(1);
        measure(0, 1, 0, k, nd, de, bb);
        checks++;
        if (nd !== 1 || de !== k + 1 || bb !== 0) begin
            errors++;
            $display("FAIL win0_done: pulses=%0d at edge %0d busybad=%0d expected 1 at %0d busybad 0", nd, de, bb, k + 1);
        end
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== '0) begin
                errors++;
                $display("FAIL win0_count[%0d]: got %0d expected 0", i, rd_count);
            end
        end
        checks++;
        if (spins !== '0) begin
            errors++;
            $display("FAIL win0_spins: got %b expected 0", spins);
        end

        bot_row = 8'h01;
        repeat (4) step(0);
        measure(1, 0, 0, k, nd, de, bb);
        rd_addr = 3'd0;
        #1;
        checks++;
        if (nd !== 1 || de !== k + 2 || rd_count !== 16'd1) begin
            errors++;
            $display("FAIL win1: pulses=%0d edge=%0d count=%0d expected 1 %0d 1", nd, de, rd_count, k + 2);
        end
        checks++;
        if (spins !== 8'h01) begin
            errors++;
            $display("FAIL win1_spins: got %b expected 00000001", spins);
        end

        measure(65535, 0, 0, k, nd, de, bb);
        checks++;
        if (nd !== 1 || de !== k + 65536 || bb !== 0) begin
            errors++;
            $display("FAIL winmax_done: pulses=%0d at edge %0d busybad=%0d expected 1 at %0d", nd, de, bb, k + 65536);
        end
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== CNT_W'((i == 0) ? 65535 : 0)) begin
                errors++;
                $display("FAIL winmax_count[%0d]: got %0d expected %0d", i, rd_count, (i == 0) ? 65535 : 0);
            end
        end
        checks++;
        if (spins !== 8'h01) begin
            errors++;
            $display("FAIL winmax_spins: got %b expected 00000001", spins);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        bot_row = 8'h01;
        window  = 16'd1000;
        start   = 1'b1;
        step(0);
        start = 1'b0;
        repeat (299) step(0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy_before: got %0b expected 1", busy);
        end
        axi_rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || spins !== '0) begin
            errors++;
            $display("FAIL rstmid_flags: busy=%0b done=%0b spins=%b expected 0 0 0", busy, done, spins);
        end
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== '0) begin
                errors++;
                $display("FAIL rstmid_count[%0d]: got %0d expected 0", i, rd_count);
            end
        end
        repeat (3) step(0);
        axi_rstn = 1'b1;
        nd = 0;
        for (int c = 0; c < 1100; c++) begin
            step(0);
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL rstmid_nodone: active cycles=%0d expected 0", nd);
        end
    endtask

    task automatic test_start_busy();
        int k, nd, de, bb, ex;
        repeat (4) step(1);
        measure(50, 1, 20, k, nd, de, bb);
        checks++;
        if (nd !== 1 || de !== k + 51 || bb !== 0) begin
            errors++;
            $display("FAIL busy_restart_done: pulses=%0d at edge %0d busybad=%0d expected 1 at %0d", nd, de, bb, k + 51);
        end
        for (int i = 0; i < N; i++) begin
            ex = model_count(i, k, 50);
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== CNT_W'(ex)) begin
                errors++;
                $display("FAIL busy_restart_count[%0d]: got %0d expected %0d", i, rd_count, ex);
            end
        end
    endtask

    task automatic test_hold_readback();
        int k, nd, de, bb, a;
        int exc [N];
        logic [N-1:0] es;
        repeat (4) step(1);
        measure(30, 1, 0, k, nd, de, bb);
        es = '0;
        for (int i = 0; i < N; i++) begin
            exc[i] = model_count(i, k, 30);
            es[i]  = (exc[i] > 15);
        end
        checks++;
        if (spins !== es) begin
            errors++;
            $display("FAIL hold_spins_initial: got %b expected %b", spins, es);
        end
        for (int c = 0; c < 24; c++) begin
            step(1);
            a = c % N;
            rd_addr = 3'(a);
            #1;
            checks++;
            if (rd_count !== CNT_W'(exc[a]) || spins !== es) begin
                errors++;
                $display("FAIL hold_readback[%0d]: count=%0d spins=%b expected %0d %b", a, rd_count, spins, exc[a], es);
            end
        end
        window = 16'd10;
        start  = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i);
            #1;
            checks++;
            if (rd_count !== '0 || spins !== es) begin
                errors++;
                $display("FAIL restart_clear[%0d]: count=%0d spins=%b expected 0 %b", i, rd_count, spins, es);
            end
        end
        repeat (15) step(1);
    endtask

    task automatic test_random();
        int k, nd, de, bb, w, ex;
        logic [N-1:0] es;
        for (int r = 0; r < 6; r++) begin
            w = int'($urandom_range(1, 40));
            repeat (int'($urandom_range(1, 4))) step(1);
            measure(w, 1, 0, k, nd, de, bb);
            checks++;
            if (nd !== 1 || de !== k + w + 1 || bb !== 0) begin
                errors++;
                $display("FAIL rand_done[%0d]: pulses=%0d edge=%0d busybad=%0d expected 1 %0d 0", r, nd, de, bb, k + w + 1);
            end
            es = '0;
            for (int i = 0; i < N; i++) begin
                ex = model_count(i, k, w);
                es[i] = (ex > w / 2);
                rd_addr = 3'(i);
                #1;
                checks++;
                if (rd_count !== CNT_W'(ex)) begin
                    errors++;
                    $display("FAIL rand_count[%0d][%0d]: got %0d expected %0d", r, i, rd_count, ex);
                end
            end
            checks++;
            if (spins !== es) begin
                errors++;
                $display("FAIL rand_spins[%0d]: got %b expected %b", r, spins, es);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        test_reset();
        test_static_antiphase();
        test_square();
        test_window_edges();
        test_reset_mid();
        test_start_busy();
        test_hold_readback();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
